count_sequencer: RTL and testbench

//   Upstream feeder for the down-counter (ports clock/in/latch/dec/zero).

---
 rtl/count_sequencer.sv | 176 +++++++++++++++++
 tb/tb_count_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// count_sequencer: queues load values and drives one down-counter countdown per value, with a stuck-counter watchdog.
// Latency: push at edge 0 into an idle, empty block gives latch in cycle 2, dec from cycle 4, done in cycle 5+V.
// Backpressure: req_ready drops whenever the FIFO is full, and a pop in the same cycle does not bypass that.

// fifo: small synchronous FIFO with occupancy output; storage is not reset.
// Latency: a push is visible at pop_dat/empty in the cycle after the push edge; no bypass.
// Backpressure: the caller must gate push with !full and pop with !empty.
module fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage write; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy update; simultaneous push and pop cancel in level.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
endmodule

module count_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    input  logic [WIDTH-1:0]         req_value,
    output logic                     req_ready,
    output logic                     latch,
    output logic [WIDTH-1:0]         in,
    output logic                     dec,
    input  logic                     zero,
    output logic                     busy,
    output logic                     done,
    output logic [CNTW-1:0]          done_count,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);
    typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DONE} state_t;

    // Watchdog gives up after 2^WIDTH+2 RUN cycles: longest legal countdown plus margin.
    localparam int              WDW      = WIDTH + 2;
    localparam logic [WDW-1:0]  WD_LIMIT = WDW'((1 << WIDTH) + 1);

    state_t           state;
    logic [WDW-1:0]   wd;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_head;

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;

    fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_dat (req_value),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    // Sequencer FSM; outputs are registered alongside the next state so they track it exactly.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            in         <= '0;
            latch      <= 1'b0;
            dec        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            done_count <= '0;
            err        <= 1'b0;
            wd         <= '0;
        end else begin
            latch <= 1'b0;
            dec   <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        in    <= fifo_head;
                        state <= LOAD;
                        latch <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= ARM;
                end
                ARM: begin
                    // Settle cycle after the load; a zero value skips decrementing entirely.
                    wd <= '0;
                    if (in == '0) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        done_count <= done_count + CNTW'(1);
                    end else begin
                        state <= RUN;
                        dec   <= 1'b1;
                    end
                end
                RUN: begin
                    if (zero) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        done_count <= done_count + CNTW'(1);
                    end else if (wd == WD_LIMIT) begin
                        err        <= 1'b1;
                        state      <= DONE;
                        done       <= 1'b1;
                        done_count <= done_count + CNTW'(1);
                    end else begin
                        wd  <= wd + 1'b1;
                        dec <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: drives count_sequencer against a saturating down-counter model and scores each countdown.
// Latency: checks latch/dec/done cycle offsets relative to the push edge on an idle block.
// Backpressure: pushes hold req_valid until req_ready, so full-FIFO stalls are exercised.
module tb_count_sequencer;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CNTW  = 8;

    logic             clock     = 1'b0;
    logic             reset_n   = 1'b0;
    logic             req_valid = 1'b0;
    logic [WIDTH-1:0] req_value = '0;
    logic             req_ready;
    logic             latch;
    logic [WIDTH-1:0] in_val;
    logic             dec;
    logic             zero;
    logic             busy;
    logic             done;
    logic [CNTW-1:0]  done_count;
    logic [2:0]       level;
    logic             err;

    // Counter model and stuck-zero switch
    logic [WIDTH-1:0] cnt      = '0;
    bit               tie_low  = 1'b0;
    bit               wd_mode  = 1'b0;

    int errors = 0;
    int checks = 0;

    count_sequencer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_value  (req_value),
        .req_ready  (req_ready),
        .latch      (latch),
        .in         (in_val),
        .dec        (dec),
        .zero       (zero),
        .busy       (busy),
        .done       (done),
        .done_count (done_count),
        .level      (level),
        .err        (err)
    );

    always #5 clock = ~clock;

    assign zero = tie_low ? 1'b0 : (cnt == '0);

    always @(posedge clock) begin
        if (latch) begin
            cnt <= in_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int val;
        bit wd;
        bit err;
    } item_t;

    item_t exp_q[$];

    int cyc            = 0;
    int pushes         = 0;
    int latches        = 0;
    int done_total     = 0;
    int last_done_cyc  = 0;
    int last_latch_cyc = 0;
    int first_dec_cyc  = 0;
    int cur_val        = 0;
    int decs           = 0;
    int eff            = 0;
    bit prev_latch     = 1'b0;
    bit prev_dec       = 1'b0;
    bit err_sticky     = 1'b0;

    // Scoreboard: enqueue on accepted push (rising edge), score on done (falling edge).
    always @(posedge clock or negedge clock) begin
        item_t e;
        if (clock) begin
            cyc++;
            if (!reset_n) begin
                exp_q.delete();
                pushes     = 0;
                latches    = 0;
                done_total = 0;
                err_sticky = 1'b0;
                prev_latch = 1'b0;
                prev_dec   = 1'b0;
            end else if (req_valid && req_ready) begin
                if (wd_mode) begin
                    err_sticky = 1'b1;
                end
                e.val = int'(req_value);
                e.wd  = wd_mode;
                e.err = err_sticky;
                exp_q.push_back(e);
                pushes++;
            end
        end else if (reset_n) begin
            if (latch) begin
                check("latch_pulse", int'(prev_latch), 0);
                cur_val        = int'(in_val);
                decs           = 0;
                eff            = 0;
                latches++;
                last_latch_cyc = cyc;
            end
            if (dec) begin
                if (!prev_dec) begin
                    first_dec_cyc = cyc;
                end
                decs++;
                if (cnt != '0) begin
                    eff++;
                end
            end
            prev_latch = latch;
            prev_dec   = dec;
            check("level", int'(level), pushes - latches);
            check("ready_vs_full", int'(req_ready), (int'(level) != DEPTH) ? 1 : 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("done_spurious", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("order", cur_val, e.val);
                    if (e.wd) begin
                        check("wd_dec_cycles", decs, (1 << WIDTH) + 2);
                    end else if (e.val == 0) begin
                        check("zero_no_dec", decs, 0);
                    end else begin
                        check("eff_decs", eff, e.val);
                    end
                    check("err_flag", int'(err), int'(e.err));
                end
                done_total++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic nclk();
        @(negedge clock);
        #1;
    endtask

    task automatic push(input int v, output int pcyc);
        int t;
        t    = 0;
        pcyc = 0;
        req_valid = 1'b1;
        req_value = WIDTH'(v);
        while (!req_ready) begin
            nclk();
            t++;
            if (t > 400) begin
                check("push_stall", t, 0);
                req_valid = 1'b0;
                return;
            end
        end
        @(posedge clock);
        #1;
        pcyc = cyc;
        nclk();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int t;
        t = 0;
        while (done_total < target) begin
            nclk();
            t++;
            if (t > budget) begin
                check("done_timeout", done_total, target);
                return;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int p;
        int t;
        int vals3 [5] = '{3, 1, 4, 2, 7};

        reset_n   = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(posedge clock);
        nclk();
        reset_n = 1'b1;

        // Reset state
        check("rst_latch", int'(latch), 0);
        check("rst_dec", int'(dec), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_done_count", int'(done_count), 0);
        check("rst_level", int'(level), 0);
        check("rst_ready", int'(req_ready), 1);

        // Single countdown of 5 with latency checks
        push(5, p);
        wait_done(1, 100);
        check("t1_latch_cycle", last_latch_cyc - p + 1, 2);
        check("t1_dec_cycle", first_dec_cyc - p + 1, 4);
        check("t1_done_cycle", last_done_cyc - p + 1, 10);
        nclk();
        check("t1_done_pulse", int'(done), 0);
        check("t1_done_count", int'(done_count), 1);
        check("t1_busy", int'(busy), 0);
        check("t1_err", int'(err), 0);
        check("t1_in_held", int'(in_val), 5);

        // Zero value: no dec, done in cycle 4
        push(0, p);
        wait_done(2, 100);
        check("t2_done_cycle", last_done_cyc - p + 1, 4);
        nclk();
        check("t2_done_count", int'(done_count), 2);

        // Back-to-back pushes fill the FIFO
        foreach (vals3[i]) begin
            push(vals3[i], p);
        end
        check("t3_level_full", int'(level), 4);
        check("t3_ready_full", int'(req_ready), 0);
        push(6, p);
        wait_done(8, 400);
        nclk();
        check("t3_done_count", int'(done_count), 8);

        // Stuck counter: watchdog fires, next value still runs
        tie_low = 1'b1;
        wd_mode = 1'b1;
        push(9, p);
        wd_mode = 1'b0;
        push(2, p);
        wait_done(9, 200);
        tie_low = 1'b0;
        wait_done(10, 100);
        nclk();
        check("t4_err", int'(err), 1);
        check("t4_done_count", int'(done_count), 10);

        // Reset in the middle of RUN
        push(8, p);
        t = 0;
        while (!dec && t < 50) begin
            nclk();
            t++;
        end
        check("t5_dec_seen", int'(dec), 1);
        repeat (2) nclk();
        check("t5_busy_before", int'(busy), 1);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("t5_dec", int'(dec), 0);
        check("t5_latch", int'(latch), 0);
        check("t5_level", int'(level), 0);
        check("t5_done_count", int'(done_count), 0);
        check("t5_err", int'(err), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_done", int'(done), 0);
        nclk();
        reset_n = 1'b1;
        nclk();
        check("t5_ready", int'(req_ready), 1);
        check("t5_stays_idle", int'(busy), 0);

        // done_count wrap
        for (int i = 0; i < 255; i++) begin
            push(0, p);
        end
        wait_done(255, 3000);
        nclk();
        check("t6_done_count_255", int'(done_count), 255);
        push(0, p);
        wait_done(256, 100);
        nclk();
        check("t6_done_count_wrap", int'(done_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
